seg14_scroll_ctrl: RTL and testbench

Display controller for the 12-digit 14-segment panel. It holds a double-buffered message of up to 32 character codes and time-multiplexes the digit selects. It scrolls the message across the panel when the message is longer than the panel. A host loads the shadow buffer through a valid/ready write port, then commits it; the controller swaps buffers only on a frame boundary, so no frame ever shows a torn message.

---
 rtl/seg14_pkg.sv | 39 +++
 rtl/seg14_font.sv | 21 ++
 rtl/seg14_scroll_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seg14_scroll_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment scrolling display controller:
// character codes, glyph tables, FSM state type and fixed port widths.
package seg14_pkg;

  localparam int unsigned CHAR_W = 6;   // character code width
  localparam int unsigned SEG_W  = 14;  // segment pattern width, bit13 = segment a
  localparam int unsigned ADDR_W = 5;   // message buffer index width
  localparam int unsigned LEN_W  = 6;   // message length width (0..32)

  // Character codes
  localparam logic [CHAR_W-1:0] CH_SPACE = 6'd0;
  localparam logic [CHAR_W-1:0] CH_A     = 6'd1;
  localparam logic [CHAR_W-1:0] CH_Z     = 6'd26;
  localparam logic [CHAR_W-1:0] CH_0     = 6'd27;
  localparam logic [CHAR_W-1:0] CH_9     = 6'd36;

  // Segment order, msb first: a b c d e f g1 g2 h i j k l m
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 14'h0000;

  localparam logic [SEG_W-1:0] GLYPH_ALPHA [26] = '{
    14'h3BC0, 14'h3C52, 14'h2700, 14'h3C12, 14'h2780, 14'h2380, // A B C D E F
    14'h2F40, 14'h1BC0, 14'h2412, 14'h1E00, 14'h038C, 14'h0700, // G H I J K L
    14'h1B28, 14'h1B24, 14'h3F00, 14'h33C0, 14'h3F04, 14'h33C4, // M N O P Q R
    14'h2DC0, 14'h2012, 14'h1F00, 14'h0309, 14'h1B05, 14'h002D, // S T U V W X
    14'h002A, 14'h2409                                          // Y Z
  };

  localparam logic [SEG_W-1:0] GLYPH_DIGIT [10] = '{
    14'h3F09, 14'h1808, 14'h36C0, 14'h3C40, 14'h19C0,           // 0 1 2 3 4
    14'h2584, 14'h2FC0, 14'h3800, 14'h3FC0, 14'h3DC0            // 5 6 7 8 9
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/seg14_font.sv
// Character-code to 14-segment glyph decoder (purely combinational).
//   code  : 6-bit character code
//   seg_c : 14-bit segment pattern, bit13 = segment a; unknown codes are blank
module seg14_font
  import seg14_pkg::*;
(
  input  logic [CHAR_W-1:0] code,
  output logic [SEG_W-1:0]  seg_c
);

  // Letters and digits occupy two contiguous code ranges.
  always_comb begin
    seg_c = GLYPH_BLANK;
    if (code >= CH_A && code <= CH_Z) begin
      seg_c = GLYPH_ALPHA[5'(code - CH_A)];
    end else if (code >= CH_0 && code <= CH_9) begin
      seg_c = GLYPH_DIGIT[4'(code - CH_0)];
    end
  end

endmodule

// File: rtl/seg14_scroll_ctrl.sv
// Multiplexed, scrolling 14-segment panel controller with a double-buffered
// message. The host fills the shadow buffer and commits; the active buffer
// is replaced only at a frame end (or immediately when idle).
//   clk, rst_n  : clock, async active-low reset
//   en          : 1 = scan the panel, 0 = blank and idle
//   wr_valid/wr_ready, wr_addr, wr_char, wr_commit, msg_len : host write port
//   sel         : one-hot digit select, bit0 = leftmost
//   segm        : segment pattern of the selected digit
//   frame_tick  : pulse on the last cycle of each frame
module seg14_scroll_ctrl
  import seg14_pkg::*;
#(
  parameter int unsigned DIGITS        = 12,
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned SCROLL_FRAMES = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              wr_commit,
  input  logic [LEN_W-1:0]  msg_len,
  output logic [DIGITS-1:0] sel,
  output logic [SEG_W-1:0]  segm,
  output logic              frame_tick
);

  localparam int unsigned DIGIT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  localparam int unsigned FRAME_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int unsigned IDX_W   = LEN_W + 1;

  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(DIGITS - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SCROLL_FRAMES - 1);
  localparam logic [LEN_W-1:0]   LEN_DIGITS = LEN_W'(DIGITS);
  localparam logic [LEN_W-1:0]   LEN_DEPTH  = LEN_W'(DEPTH);

  state_t              state, state_n;
  logic [DIGIT_W-1:0]  digit, digit_n;
  logic [PRESC_W-1:0]  presc, presc_n;
  logic [DIGITS-1:0]   sel_n;
  logic [SEG_W-1:0]    segm_n;
  logic                tick_n;

  logic [CHAR_W-1:0]   act_buf [DEPTH];
  logic [CHAR_W-1:0]   shd_buf [DEPTH];
  logic [LEN_W-1:0]    act_len, pend_len;
  logic [LEN_W-1:0]    offset, off_inc;
  logic [FRAME_W-1:0]  frame_cnt;
  logic                commit_pend;

  logic                wr_xfer, frame_end, swap, scroll_adv, scroll_step;
  logic [DIGIT_W-1:0]  look_digit;
  logic [LEN_W-1:0]    len_n, off_n;
  logic [IDX_W-1:0]    sum, idx;
  logic [ADDR_W-1:0]   rd_addr;
  logic                blank;
  logic [CHAR_W-1:0]   look_char;
  logic [SEG_W-1:0]    look_seg;

  // Frame-end events: swap takes priority over a scroll step.
  assign wr_xfer     = wr_valid & wr_ready;
  assign frame_end   = (state == ST_GAP) && (digit == LAST_DIGIT) && en;
  assign swap        = commit_pend && (frame_end || (state == ST_IDLE));
  assign scroll_adv  = frame_end && !swap && (act_len > LEN_DIGITS);
  assign scroll_step = scroll_adv && (frame_cnt == FRAME_LAST);
  assign off_inc     = (LEN_W'(offset + LEN_W'(1)) == act_len) ? '0 : LEN_W'(offset + LEN_W'(1));

  // Character for the digit about to be lit, seen through any buffer swap or
  // scroll step taking effect on this same edge.
  always_comb begin
    look_digit = '0;
    if (state == ST_GAP && digit != LAST_DIGIT) begin
      look_digit = digit + DIGIT_W'(1);
    end
    len_n   = swap ? pend_len : act_len;
    off_n   = swap ? '0 : (scroll_step ? off_inc : offset);
    sum     = IDX_W'(off_n) + IDX_W'(look_digit);
    idx     = (sum >= IDX_W'(len_n)) ? (sum - IDX_W'(len_n)) : sum;
    blank   = (len_n == '0) ||
              ((len_n <= LEN_DIGITS) && (IDX_W'(look_digit) >= IDX_W'(len_n)));
    rd_addr = ADDR_W'(idx);
    look_char = CH_SPACE;
    if (!blank) begin
      look_char = swap ? shd_buf[rd_addr] : act_buf[rd_addr];
    end
  end

  seg14_font u_font (
    .code  (look_char),
    .seg_c (look_seg)
  );

  // Scan sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n = state;
    digit_n = digit;
    presc_n = presc;
    sel_n   = '0;
    segm_n  = '0;
    tick_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en) begin
          state_n = ST_SHOW;
          digit_n = '0;
          presc_n = '0;
          sel_n   = DIGITS'(1) << look_digit;
          segm_n  = look_seg;
        end
      end
      ST_SHOW: begin
        if (presc == PRESC_LAST) begin
          state_n = ST_GAP;
          presc_n = '0;
          tick_n  = (digit == LAST_DIGIT);
        end else begin
          presc_n = presc + PRESC_W'(1);
          sel_n   = sel;
          segm_n  = segm;
        end
      end
      ST_GAP: begin
        state_n = ST_SHOW;
        digit_n = look_digit;
        presc_n = '0;
        sel_n   = DIGITS'(1) << look_digit;
        segm_n  = look_seg;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (!en) begin
      state_n = ST_IDLE;
      digit_n = '0;
      presc_n = '0;
      sel_n   = '0;
      segm_n  = '0;
      tick_n  = 1'b0;
    end
  end

  // Scan counters, outputs, buffers, scroll position and write handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit       <= '0;
      presc       <= '0;
      sel         <= '0;
      segm        <= '0;
      frame_tick  <= 1'b0;
      wr_ready    <= 1'b1;
      commit_pend <= 1'b0;
      act_len     <= '0;
      pend_len    <= '0;
      offset      <= '0;
      frame_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        act_buf[i] <= CH_SPACE;
        shd_buf[i] <= CH_SPACE;
      end
    end else begin
      digit      <= digit_n;
      presc      <= presc_n;
      sel        <= sel_n;
      segm       <= segm_n;
      frame_tick <= tick_n;

      if (swap) begin
        for (int i = 0; i < DEPTH; i++) begin
          act_buf[i] <= shd_buf[i];
        end
        act_len     <= pend_len;
        offset      <= '0;
        frame_cnt   <= '0;
        commit_pend <= 1'b0;
        wr_ready    <= 1'b1;
      end else if (scroll_step) begin
        offset    <= off_inc;
        frame_cnt <= '0;
      end else if (scroll_adv) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end

      if (wr_xfer) begin
        if (wr_commit) begin
          pend_len    <= (msg_len > LEN_DEPTH) ? LEN_DEPTH : msg_len;
          commit_pend <= 1'b1;
          wr_ready    <= 1'b0;
        end else begin
          shd_buf[wr_addr] <= wr_char;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg14_scroll_ctrl.sv
// Scoreboard bench for seg14_scroll_ctrl: a frame-position reference model
// pushes the expected outputs every clock; a monitor pops and compares.
module tb_seg14_scroll_ctrl;
  import seg14_pkg::*;

  localparam int DIGITS = 12;
  localparam int DEPTH  = 32;
  localparam int SD     = 4;
  localparam int SF     = 2;
  localparam int FRAME  = DIGITS * (SD + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [4:0]        wr_addr = '0;
  logic [5:0]        wr_char = '0;
  logic              wr_commit = 1'b0;
  logic [5:0]        msg_len = '0;
  logic [DIGITS-1:0] sel;
  logic [13:0]       segm;
  logic              frame_tick;

  seg14_scroll_ctrl #(
    .DIGITS(DIGITS), .DEPTH(DEPTH), .SCAN_DIV(SD), .SCROLL_FRAMES(SF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_char(wr_char), .wr_commit(wr_commit), .msg_len(msg_len),
    .sel(sel), .segm(segm), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DIGITS-1:0] sel;
    logic [13:0]       segm;
    logic              tick;
    logic              ready;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: scan position within the frame plus message state.
  bit       m_scan, m_pend, m_ready, m_acc;
  int       m_pos, m_len, m_off, m_fcnt, m_plen;
  logic [5:0] m_act [32];
  logic [5:0] m_shd [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t (model pos %0d len %0d off %0d)",
                  name, act, exp, $time, m_pos, m_len, m_off);
  endtask

  function automatic logic [13:0] ref_glyph(input logic [5:0] c);
    int v = int'(c);
    if (v >= 1 && v <= 26) return GLYPH_ALPHA[5'(v - 1)];
    if (v >= 27 && v <= 36) return GLYPH_DIGIT[4'(v - 27)];
    return 14'h0;
  endfunction

  function automatic logic [5:0] m_char(input int k);
    if (m_len == 0) return 6'd0;
    if (m_len <= DIGITS) return (k < m_len) ? m_act[5'(k)] : 6'd0;
    return m_act[5'((m_off + k) % m_len)];
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int d;
    e = '0;
    e.ready = m_ready;
    if (m_scan) begin
      d = m_pos / (SD + 1);
      if ((m_pos % (SD + 1)) < SD) begin
        e.sel[4'(d)] = 1'b1;
        e.segm = ref_glyph(m_char(d));
      end
      e.tick = (m_pos == FRAME - 1);
    end
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_act[i] = 6'd0;
      m_shd[i] = 6'd0;
    end
    m_scan = 0; m_pos = 0; m_len = 0; m_off = 0; m_fcnt = 0;
    m_plen = 0; m_pend = 0; m_ready = 1; m_acc = 0;
  endfunction

  function automatic void model_step();
    bit fe, sw, xf;
    int ml;
    fe = m_scan && (m_pos == FRAME - 1) && en;
    sw = m_pend && (fe || !m_scan);
    xf = wr_valid && m_ready;
    m_acc = xf;
    if (fe && !sw && m_len > DIGITS) begin
      m_fcnt++;
      if (m_fcnt == SF) begin
        m_fcnt = 0;
        m_off = (m_off + 1) % m_len;
      end
    end
    if (sw) begin
      m_act = m_shd;
      m_len = m_plen; m_off = 0; m_fcnt = 0; m_pend = 0; m_ready = 1;
    end
    if (xf) begin
      if (wr_commit) begin
        ml = int'(msg_len);
        m_plen = (ml > DEPTH) ? DEPTH : ml;
        m_pend = 1; m_ready = 0;
      end else begin
        m_shd[wr_addr] = wr_char;
      end
    end
    if (!en) begin
      m_scan = 0; m_pos = 0;
    end else if (!m_scan) begin
      m_scan = 1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
  endfunction

  // Model: one expectation per clock edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      q.push_back(model_out());
    end
  end

  // Monitor: compare away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("scan_out", 32'({sel, segm, frame_tick}), 32'({e.sel, e.segm, e.tick}));
        chk("wr_ready", 32'(wr_ready), 32'(e.ready));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic xfer(input bit commit, input int a, input int c, input int l);
    bit done = 0;
    wr_valid = 1'b1; wr_commit = commit;
    wr_addr = 5'(a); wr_char = 6'(c); msg_len = 6'(l);
    for (int n = 0; n < 400 && !done; n++) begin
      step();
      done = m_acc;
    end
    wr_valid = 1'b0; wr_commit = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL xfer_timeout: transfer not accepted within 400 cycles at t=%0t", $time);
    end
  endtask

  // kind 0: mid-frame; 1: mid-frame of a frame that ends in a scroll step; 2: mid-digit lit
  task automatic wait_model(input int kind);
    bit hit = 0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      case (kind)
        0: hit = m_scan && m_pos == 20;
        1: hit = m_scan && m_ready && m_len > DIGITS && m_fcnt == SF - 1 &&
                 m_pos >= 10 && m_pos <= 40;
        default: hit = m_scan && m_pos > 20 && (m_pos % (SD + 1)) == 2;
      endcase
      if (!hit) step();
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL wait_timeout: model condition %0d not reached at t=%0t", kind, $time);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 32'({sel, segm, frame_tick}), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  initial begin
    int daniel [6] = '{4, 1, 14, 9, 5, 12};
    #1 rst_n = 1'b0;
    #1 chk("reset_out", 32'({sel, segm, frame_tick, wr_ready}), 32'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();

    // Empty message scan
    en = 1'b1;
    repeat (2 * FRAME + 5) step();

    // "DANIEL", committed mid-frame
    wait_model(0);
    for (int i = 0; i < 6; i++) xfer(0, i, daniel[i], 0);
    xfer(1, 0, 0, 6);
    repeat (5 * FRAME) step();

    // 14-character scrolling message across a full offset wrap
    for (int i = 0; i < 14; i++) xfer(0, i, $urandom_range(1, 36), 0);
    xfer(1, 0, 0, 14);
    repeat (30 * FRAME) step();

    // en drops mid-digit, offset preserved on restart
    wait_model(2);
    en = 1'b0;
    repeat (6) step();
    en = 1'b1;
    repeat (2 * FRAME) step();

    // Commit lands on the same frame end as a scroll step
    for (int i = 0; i < 20; i++) xfer(0, i, $urandom_range(1, 36), 0);
    wait_model(1);
    xfer(1, 0, 0, 20);
    repeat (3 * FRAME) step();

    // Length clamp to 32
    for (int i = 20; i < 32; i++) xfer(0, i, $urandom_range(1, 36), 0);
    xfer(1, 0, 0, 40);
    repeat (4 * FRAME) step();

    // Unknown codes decode to blank
    xfer(0, 0, 63, 0); xfer(0, 1, 37, 0); xfer(0, 2, 0, 0);
    xfer(0, 3, 36, 0); xfer(0, 4, 27, 0);
    xfer(1, 0, 0, 5);
    repeat (2 * FRAME) step();

    // Commit while idle
    en = 1'b0;
    repeat (3) step();
    xfer(1, 0, 0, 3);
    repeat (4) step();
    en = 1'b1;
    repeat (FRAME) step();

    // en falls while a commit is pending
    wait_model(0);
    xfer(1, 0, 0, 13);
    repeat (3) step();
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    repeat (2 * FRAME) step();

    // Zero length still scans
    xfer(1, 0, 0, 0);
    repeat (FRAME + 10) step();

    // Randomised traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 5))
        0, 1: if (m_ready) xfer(0, $urandom_range(0, 31), $urandom_range(0, 63), 0);
              else step();
        2: if (m_ready) xfer(1, 0, 0, $urandom_range(0, 45));
           else step();
        3: begin
          en = 1'b0;
          repeat ($urandom_range(1, 8)) step();
          en = 1'b1;
        end
        default: repeat ($urandom_range(1, 40)) step();
      endcase
    end

    // Reset mid-frame, then buffers must read back as SPACE
    wait_model(0);
    repeat (13) step();
    pulse_reset();
    xfer(1, 0, 0, 8);
    repeat (2 * FRAME) step();

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
